// File: rtl/calc_if.sv
// Key-scanner-to-calculator bus: key events in, display/status out.
interface calc_if;
    logic        key_flag;
    logic [3:0]  key_val;
    logic [13:0] disp_val;
    logic        disp_neg;
    logic        err;
    logic        busy;
    logic        done;

    modport master (
        output key_flag, key_val,
        input  disp_val, disp_neg, err, busy, done
    );

    modport slave (
        input  key_flag, key_val,
        output disp_val, disp_neg, err, busy, done
    );
endinterface

// File: rtl/calc_ctrl.sv
// Four-function decimal calculator controller: digit entry, one-cycle add/sub/mul,
// 14-step restoring divide, registered display outputs.
module calc_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_VAL    = 9999
) (
    input logic   clk,
    input logic   rst_n,
    calc_if.slave bus
);
    typedef enum logic [2:0] {S_A, S_OP, S_B, S_CALC, S_RES} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    localparam int               CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [27:0]      MAX_W   = 28'(MAX_VAL);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [13:0]      a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       it_q, it_d;
    logic [13:0]      rem_q, rem_d, quo_q, quo_d;
    logic [13:0]      disp_q, disp_d;
    logic             neg_q, neg_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [13:0] accum(input logic [13:0] v, input logic [3:0] d);
        logic [17:0] t;
        t = 18'(v) * 18'd10 + 18'(d);
        return t[13:0];
    endfunction

    // Arithmetic datapath, evaluated every cycle and consumed only in S_CALC.
    logic [14:0] sum_w;
    logic        b_gt_a;
    logic [13:0] diff_w;
    logic [27:0] prod_w;
    logic [14:0] shift_w;
    logic [15:0] trial_w;
    logic [13:0] rem_nx, quo_nx;
    logic [3:0]  op_off;
    logic [13:0] digit_w;

    assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
    assign b_gt_a  = b_q > a_q;
    assign diff_w  = b_gt_a ? (b_q - a_q) : (a_q - b_q);
    assign prod_w  = {14'd0, a_q} * {14'd0, b_q};
    assign shift_w = {rem_q, quo_q[13]};
    assign trial_w = {1'b0, shift_w} - {2'b00, b_q};
    assign rem_nx  = trial_w[15] ? shift_w[13:0] : trial_w[13:0];
    assign quo_nx  = {quo_q[12:0], ~trial_w[15]};
    assign op_off  = bus.key_val - 4'd10;
    assign digit_w = {10'd0, bus.key_val};

    logic        key_ok, is_digit, is_op, is_eq, is_clr;
    logic        fin, fin_err, fin_neg;
    logic [13:0] fin_val;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        it_d    = it_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        disp_d  = disp_q;
        neg_d   = neg_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_neg = 1'b0;
        fin_val = '0;

        // A key landing on the done cycle is dropped.
        key_ok   = bus.key_flag && !done_q;
        is_digit = bus.key_val <= 4'd9;
        is_op    = (bus.key_val >= 4'd10) && (bus.key_val <= 4'd13);
        is_eq    = bus.key_val == 4'd14;
        is_clr   = bus.key_val == 4'd15;

        if (key_ok && is_clr && state_q != S_CALC) begin
            state_d = S_A;
            op_d    = OP_ADD;
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
            disp_d  = '0;
            neg_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_A: if (key_ok) begin
                    if (is_digit && cnt_q < CNT_MAX) begin
                        a_d    = accum(a_q, bus.key_val);
                        cnt_d  = cnt_q + 1'b1;
                        disp_d = accum(a_q, bus.key_val);
                    end else if (is_op) begin
                        op_d    = op_e'(op_off[1:0]);
                        state_d = S_OP;
                    end
                end
                S_OP: if (key_ok) begin
                    if (is_digit) begin
                        b_d     = digit_w;
                        cnt_d   = CNT_W'(1);
                        disp_d  = digit_w;
                        state_d = S_B;
                    end else if (is_op) begin
                        op_d = op_e'(op_off[1:0]);
                    end
                end
                S_B: if (key_ok) begin
                    if (is_digit && cnt_q < CNT_MAX) begin
                        b_d    = accum(b_q, bus.key_val);
                        cnt_d  = cnt_q + 1'b1;
                        disp_d = accum(b_q, bus.key_val);
                    end else if (is_eq) begin
                        busy_d  = 1'b1;
                        it_d    = '0;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    case (op_q)
                        OP_ADD: begin
                            fin     = 1'b1;
                            fin_err = 28'(sum_w) > MAX_W;
                            fin_val = sum_w[13:0];
                        end
                        OP_SUB: begin
                            fin     = 1'b1;
                            fin_err = 28'(diff_w) > MAX_W;
                            fin_val = diff_w;
                            fin_neg = b_gt_a;
                        end
                        OP_MUL: begin
                            fin     = 1'b1;
                            fin_err = prod_w > MAX_W;
                            fin_val = prod_w[13:0];
                        end
                        default: begin
                            // Iteration 0 is the load cycle; 1..14 are the restoring steps.
                            if (it_q == 4'd0) begin
                                if (b_q == '0) begin
                                    fin     = 1'b1;
                                    fin_err = 1'b1;
                                end else begin
                                    rem_d = '0;
                                    quo_d = a_q;
                                    it_d  = 4'd1;
                                end
                            end else begin
                                rem_d = rem_nx;
                                quo_d = quo_nx;
                                if (it_q == 4'd14) begin
                                    fin     = 1'b1;
                                    fin_err = 28'(quo_nx) > MAX_W;
                                    fin_val = quo_nx;
                                end else begin
                                    it_d = it_q + 4'd1;
                                end
                            end
                        end
                    endcase
                end
                S_RES: if (key_ok) begin
                    if (is_digit) begin
                        a_d     = digit_w;
                        cnt_d   = CNT_W'(1);
                        disp_d  = digit_w;
                        neg_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_A;
                    end else if (is_op && !err_q && !neg_q) begin
                        a_d     = disp_q;
                        op_d    = op_e'(op_off[1:0]);
                        state_d = S_OP;
                    end
                end
                default: state_d = S_A;
            endcase
        end

        if (fin) begin
            state_d = S_RES;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = fin_err;
            neg_d   = fin_err ? 1'b0 : fin_neg;
            disp_d  = fin_err ? 14'd0 : fin_val;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            it_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            disp_q  <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            it_q    <= it_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.disp_val = disp_q;
    assign bus.disp_neg = neg_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// Table-driven bench for calc_ctrl with a result scoreboard and hand-written
// sequences for the done-coincident key and reset-during-divide cases.
module tb_calc_ctrl;
    logic clk;
    logic rst_n;

    calc_if bus ();

    calc_ctrl #(.MAX_DIGITS(4), .MAX_VAL(9999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [13:0] disp;
        logic        neg;
        logic        err;
        int          lat;   // 0: plain key, checked next cycle; else cycles from "=" to done
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] k, input int d, input bit n, input bit e,
                                input int lat);
        vec_t v;
        v.key  = k;
        v.disp = 14'(d);
        v.neg  = n;
        v.err  = e;
        v.lat  = lat;
        vecs.push_back(v);
    endfunction

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_flag = 1'b1;
        bus.key_val  = k;
        @(negedge clk);
        bus.key_flag = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        int   cyc;
        int   busy_cnt;
        vec_t e;
        if (v.lat == 0) begin
            press(v.key);
            check({tag, ".disp"}, 32'(bus.disp_val), 32'(v.disp));
            check({tag, ".neg"},  32'(bus.disp_neg), 32'(v.neg));
            check({tag, ".err"},  32'(bus.err),      32'(v.err));
            check({tag, ".busy"}, 32'(bus.busy),     32'd0);
        end else begin
            sb_q.push_back(v);
            press(v.key);
            cyc      = 1;
            busy_cnt = 0;
            while (!bus.done && cyc < 40) begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
            e = sb_q.pop_front();
            if (!bus.done) begin
                n_vec++;
                n_err++;
                $display("FAIL %s.timeout: got no done within %0d cycles expected at %0d",
                         tag, cyc, e.lat);
            end else begin
                check({tag, ".res"},      32'(bus.disp_val), 32'(e.disp));
                check({tag, ".res_neg"},  32'(bus.disp_neg), 32'(e.neg));
                check({tag, ".res_err"},  32'(bus.err),      32'(e.err));
                check({tag, ".latency"},  32'(cyc),          32'(e.lat));
                check({tag, ".busy_len"}, 32'(busy_cnt),     32'(e.lat - 1));
                check({tag, ".busy_off"}, 32'(bus.busy),     32'd0);
            end
        end
    endtask

    task automatic apply_keys(input logic [3:0] k, input int d, input string tag);
        vec_t v;
        v.key  = k;
        v.disp = 14'(d);
        v.neg  = 1'b0;
        v.err  = 1'b0;
        v.lat  = 0;
        apply(v, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   done_seen;

        rst_n        = 1'b0;
        bus.key_flag = 1'b0;
        bus.key_val  = 4'd0;
        repeat (3) @(negedge clk);
        check("rst.disp", 32'(bus.disp_val), 32'd0);
        check("rst.neg",  32'(bus.disp_neg), 32'd0);
        check("rst.err",  32'(bus.err),      32'd0);
        check("rst.busy", 32'(bus.busy),     32'd0);
        check("rst.done", 32'(bus.done),     32'd0);
        rst_n = 1'b1;

        // 12 + 34
        add(1, 1, 0, 0, 0);  add(2, 12, 0, 0, 0); add(10, 12, 0, 0, 0);
        add(3, 3, 0, 0, 0);  add(4, 34, 0, 0, 0); add(14, 46, 0, 0, 2);
        // 5 - 8, then "+" must not chain off a negative result
        add(15, 0, 0, 0, 0); add(5, 5, 0, 0, 0);  add(11, 5, 0, 0, 0);
        add(8, 8, 0, 0, 0);  add(14, 3, 1, 0, 2); add(10, 3, 1, 0, 0);
        add(4, 4, 0, 0, 0);  add(10, 4, 0, 0, 0); add(1, 1, 0, 0, 0);
        add(14, 5, 0, 0, 2);
        // 100 / 7
        add(15, 0, 0, 0, 0); add(1, 1, 0, 0, 0);  add(0, 10, 0, 0, 0);
        add(0, 100, 0, 0, 0); add(13, 100, 0, 0, 0); add(7, 7, 0, 0, 0);
        add(14, 14, 0, 0, 16);
        // 9999 * 2 overflows; error blocks chaining; 5 / 0
        add(15, 0, 0, 0, 0); add(9, 9, 0, 0, 0);  add(9, 99, 0, 0, 0);
        add(9, 999, 0, 0, 0); add(9, 9999, 0, 0, 0); add(12, 9999, 0, 0, 0);
        add(2, 2, 0, 0, 0);  add(14, 0, 0, 1, 2); add(10, 0, 0, 1, 0);
        add(5, 5, 0, 0, 0);  add(13, 5, 0, 0, 0); add(0, 0, 0, 0, 0);
        add(14, 0, 0, 1, 2);
        // digit limit, "=" ignored in S_A, clear
        add(15, 0, 0, 0, 0); add(1, 1, 0, 0, 0);  add(2, 12, 0, 0, 0);
        add(3, 123, 0, 0, 0); add(4, 1234, 0, 0, 0); add(5, 1234, 0, 0, 0);
        add(14, 1234, 0, 0, 0); add(15, 0, 0, 0, 0);
        // 6 * 7 then chain + 8
        add(6, 6, 0, 0, 0);  add(12, 6, 0, 0, 0); add(7, 7, 0, 0, 0);
        add(14, 42, 0, 0, 2); add(10, 42, 0, 0, 0); add(8, 8, 0, 0, 0);
        add(14, 50, 0, 0, 2);
        // operator replaced in S_OP; "=" ignored in S_OP; 5 - 5 is non-negative zero
        add(15, 0, 0, 0, 0); add(3, 3, 0, 0, 0);  add(10, 3, 0, 0, 0);
        add(11, 3, 0, 0, 0); add(14, 3, 0, 0, 0); add(1, 1, 0, 0, 0);
        add(14, 2, 0, 0, 2);
        add(15, 0, 0, 0, 0); add(5, 5, 0, 0, 0);  add(11, 5, 0, 0, 0);
        add(5, 5, 0, 0, 0);  add(14, 0, 0, 0, 2);
        // 9999 + 1 overflows; 9999 / 1 exercises all quotient bits
        add(15, 0, 0, 0, 0); add(9, 9, 0, 0, 0);  add(9, 99, 0, 0, 0);
        add(9, 999, 0, 0, 0); add(9, 9999, 0, 0, 0); add(10, 9999, 0, 0, 0);
        add(1, 1, 0, 0, 0);  add(14, 0, 0, 1, 2);
        add(15, 0, 0, 0, 0); add(9, 9, 0, 0, 0);  add(9, 99, 0, 0, 0);
        add(9, 999, 0, 0, 0); add(9, 9999, 0, 0, 0); add(13, 9999, 0, 0, 0);
        add(1, 1, 0, 0, 0);  add(14, 9999, 0, 0, 16);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Keys during S_CALC and on the done cycle are dropped.
        apply_keys(15, 0, "drop.clr");
        apply_keys(2, 2, "drop.a");
        apply_keys(10, 2, "drop.op");
        apply_keys(3, 3, "drop.b");
        v.key = 14; v.disp = 14'd5; v.neg = 1'b0; v.err = 1'b0; v.lat = 2;
        sb_q.push_back(v);
        @(negedge clk);
        bus.key_flag = 1'b1;
        bus.key_val  = 4'd14;
        @(negedge clk);
        bus.key_val  = 4'd9;
        check("drop.busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.key_val  = 4'd7;
        v = sb_q.pop_front();
        check("drop.done", 32'(bus.done),     32'd1);
        check("drop.res",  32'(bus.disp_val), 32'(v.disp));
        @(negedge clk);
        bus.key_flag = 1'b0;
        check("drop.hold",  32'(bus.disp_val), 32'(v.disp));
        check("drop.pulse", 32'(bus.done),     32'd0);
        apply_keys(8, 8, "drop.after");

        // Reset in the middle of a divide.
        apply_keys(15, 0, "abort.clr");
        apply_keys(1, 1, "abort.a1");
        apply_keys(0, 10, "abort.a2");
        apply_keys(0, 100, "abort.a3");
        apply_keys(13, 100, "abort.op");
        apply_keys(7, 7, "abort.b");
        press(4'd14);
        repeat (7) @(negedge clk);
        check("abort.busy_mid", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort.disp", 32'(bus.disp_val), 32'd0);
        check("abort.neg",  32'(bus.disp_neg), 32'd0);
        check("abort.err",  32'(bus.err),      32'd0);
        check("abort.busy", 32'(bus.busy),     32'd0);
        check("abort.done", 32'(bus.done),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);
        apply_keys(2, 2, "abort.p2");
        apply_keys(10, 2, "abort.pop");
        apply_keys(3, 3, "abort.p3");
        v.key = 14; v.disp = 14'd5; v.neg = 1'b0; v.err = 1'b0; v.lat = 2;
        apply(v, "abort.sum");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 The module SHALL have parameter MAX_DIGITS, default 4, giving the maximum decimal digits per operand.
REQ-002 The module SHALL have parameter MAX_VAL, default 9999, giving the largest displayable magnitude.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the system clock (50 MHz).
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the system reset; reset is asynchronous and active-low.
REQ-005 Port key_flag SHALL be an input, 1 bit wide, and is a 1-cycle pulse from the key scanner meaning key_val is valid.
REQ-006 Port key_val SHALL be an input, 4 bits wide: 0-9 digit, 10 "+", 11 "-", 12 "×", 13 "÷", 14 "=", 15 clear.
REQ-007 Port disp_val SHALL be an output, 14 bits wide, giving the unsigned magnitude to display.
REQ-008 Port disp_neg SHALL be an output, 1 bit wide, and is high when the displayed result is negative.
REQ-009 Port err SHALL be an output, 1 bit wide: overflow or divide-by-zero; sticky until clear or new entry.
REQ-010 Port busy SHALL be an output, 1 bit wide, and is high while a calculation is in progress.
REQ-011 Port done SHALL be an output, 1 bit wide, and is a 1-cycle pulse when a result becomes valid.

Function
REQ-012 The FSM SHALL have exactly these states: S_A (enter A), S_OP (operator held), S_B (enter B), S_CALC, S_RES; registers: A, B (14 b), op (2 b), digit counter.
REQ-013 All outputs SHALL be registered; a key accepted at cycle N SHALL be reflected on disp_val at N+1.
REQ-014 Key 15 (clear) SHALL, in any state except S_CALC, zero A, B, op, disp_val, disp_neg and err, and go to S_A.
REQ-015 In S_A, a digit SHALL set A = A*10 + d if fewer than MAX_DIGITS digits have been entered, otherwise it SHALL be ignored; disp_val = A.
REQ-016 In S_A, an operator SHALL latch op and go to S_OP; "=" SHALL be ignored.
REQ-017 In S_OP, a digit SHALL set B = d and go to S_B; a further operator SHALL replace op; "=" SHALL be ignored; disp_val SHALL stay A.
REQ-018 In S_B, a digit SHALL accumulate into B under the same rule as S_A; disp_val = B; an operator SHALL be ignored; "=" SHALL go to S_CALC.
REQ-019 In S_CALC, busy SHALL be 1 and all key_flag pulses SHALL be dropped (not queued).
REQ-020 Add, subtract and multiply SHALL take one S_CALC cycle: "=" at N, busy at N+1, result and done at N+2.
REQ-021 Subtract SHALL output |A-B| with disp_neg=1 when B>A; the result 0 SHALL have disp_neg=0.
REQ-022 Divide SHALL be a sequential restoring divider: one load cycle plus 14 iteration cycles; busy is high N+1..N+15, result (quotient, truncated) and done at N+16.
REQ-023 Divide by B=0 SHALL be detected in the load cycle, exit at N+2 with err=1 and disp_val=0.
REQ-024 A result greater than MAX_VAL (28-bit product check) SHALL produce err=1 and disp_val=0.
REQ-025 In S_RES, a digit SHALL start a fresh A = d with err and disp_neg cleared, and go to S_A.
REQ-026 In S_RES, an operator SHALL chain (A = result, latch op, go to S_OP) only if err=0 and disp_neg=0, and SHALL otherwise be ignored; "=" SHALL be ignored.
REQ-027 A key_flag pulse coincident with the done pulse SHALL be dropped.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously enter S_A with A=B=0, op=0, digit counter=0, disp_val=0, disp_neg=0, err=0, busy=0, done=0.
REQ-029 Reset asserted mid-divide SHALL abort the divide immediately, with no done pulse after release.

Verification
REQ-030 The bench SHALL check: keys 1,2,+,3,4,= -> disp 12, then 34, then 46 with done 2 cycles after "=", disp_neg=0.
REQ-031 The bench SHALL check: keys 5,-,8,= -> disp_val=3, disp_neg=1; a following "+" is ignored and the state stays S_RES.
REQ-032 The bench SHALL check: keys 1,0,0,÷,7,= -> busy for 15 cycles, then disp_val=14 with done at N+16.
REQ-033 The bench SHALL check: keys 9,9,9,9,×,2,= -> err=1, disp_val=0; 5,÷,0,= -> err=1 at N+2.
REQ-034 The bench SHALL check: keys 1,2,3,4,5 -> disp 1234; key 15 -> disp 0 in S_A.
REQ-035 The bench SHALL check: reset pulsed at divide iteration 7 -> all outputs 0, no done; 2,+,3,= afterwards -> 5.
